// File: rtl/cdb_arbiter_if.sv
// Packet types shared by the execution units, the CDB arbiter and its
// consumers, plus the bus interface that bundles the request and broadcast
// signals.
package cdb_arbiter_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      dest_reg_idx;
    logic [5:0]      Tag;
    logic            take_branch;
    logic            halt;
    logic            illegal;
    logic            valid;
  } EX_PACKET;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] Value;
    logic [4:0]      dest_reg_idx;
    logic [5:0]      Tag;
    logic            take_branch;
    logic            halt;
    logic            illegal;
    logic            done;
    logic            valid;
  } CDB_PACKET;
endpackage

interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import cdb_arbiter_pkg::*;
  localparam int unsigned GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  EX_PACKET [NUM_REQ-1:0]       req_packet;
  logic [NUM_REQ-1:0]           req_ready;
  CDB_PACKET                    cdb_packet;
  logic                         wb_regfile_en;
  logic [4:0]                   wb_regfile_idx;
  logic [XLEN-1:0]              wb_regfile_data;
  logic [GW-1:0]                grant_id;

  // Execution-unit / consumer side
  modport master (
    output req_valid, req_packet,
    input  req_ready, cdb_packet, wb_regfile_en, wb_regfile_idx,
           wb_regfile_data, grant_id
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_packet,
    output req_ready, cdb_packet, wb_regfile_en, wb_regfile_idx,
           wb_regfile_data, grant_id
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one small FIFO per execution unit, one head entry
// granted per cycle, converted into a registered CDB packet that also drives
// the architectural register-file write port.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          squash,
  cdb_arbiter_if.slave  bus
);
  import cdb_arbiter_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam logic [GW:0]  NREQ_W = (GW+1)'(NUM_REQ);
  localparam logic [CW-1:0] FULL_W = CW'(DEPTH);

  EX_PACKET        r_mem   [NUM_REQ][DEPTH];
  logic [PW-1:0]   r_head  [NUM_REQ];
  logic [PW-1:0]   r_tail  [NUM_REQ];
  logic [CW-1:0]   r_count [NUM_REQ];
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant_id;
  CDB_PACKET       r_cdb;

  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;
  logic [NUM_REQ-1:0] w_nonempty;
  logic [NUM_REQ-1:0] w_rot;
  logic               w_found;
  logic [GW-1:0]      w_off;
  logic [GW:0]        w_sum;
  logic [GW-1:0]      w_winner;
  logic [GW-1:0]      w_rr_next;
  EX_PACKET           w_head;
  logic               w_tb;
  CDB_PACKET          w_cdb_next;

  // Ready comes from registered occupancy only; push needs valid and ready
  always_comb begin
    w_ready = '0;
    w_push  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_ready[i] = (r_count[i] != FULL_W) && reset;
      w_push[i]  = bus.req_valid[i] && w_ready[i];
    end
  end

  // Round-robin pick: rotate the non-empty mask so rr_ptr sits at bit 0,
  // take the lowest set bit, then rotate the offset back to a requester index
  always_comb begin
    w_nonempty = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_nonempty[i] = (r_count[i] != '0);
    end
    w_rot   = NUM_REQ'({w_nonempty, w_nonempty} >> r_rr_ptr);
    w_found = 1'b0;
    w_off   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = GW'(k);
      end
    end
    w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_winner = (w_sum >= NREQ_W) ? GW'(w_sum - NREQ_W) : w_sum[GW-1:0];
    w_pop    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pop[i] = w_found && (w_winner == GW'(i));
    end
    w_rr_next = (w_winner == GW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  end

  // Convert the winning head entry into the next CDB broadcast
  always_comb begin
    w_head     = r_mem[w_winner][r_head[w_winner]];
    w_tb       = w_head.take_branch && w_head.valid;
    w_cdb_next = '0;
    w_cdb_next.inst         = w_head.inst;
    w_cdb_next.PC           = w_head.PC;
    w_cdb_next.NPC          = w_head.NPC;
    w_cdb_next.alu_result   = w_head.alu_result;
    w_cdb_next.dest_reg_idx = w_head.dest_reg_idx;
    w_cdb_next.Tag          = w_head.Tag;
    w_cdb_next.halt         = w_head.halt;
    w_cdb_next.illegal      = w_head.illegal;
    w_cdb_next.take_branch  = w_tb;
    w_cdb_next.Value        = w_tb ? w_head.NPC : w_head.alu_result;
    w_cdb_next.done         = 1'b0;
    w_cdb_next.valid        = 1'b1;
  end

  // FIFO payload storage; stale entries are harmless once counts clear
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_push[i]) r_mem[i][r_tail[i]] <= bus.req_packet[i];
    end
  end

  // FIFO pointers and occupancy; squash and reset drop everything buffered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end
    end else if (squash) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_push[i]) r_tail[i] <= r_tail[i] + 1'b1;
        if (w_pop[i])  r_head[i] <= r_head[i] + 1'b1;
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + 1'b1;
          2'b01:   r_count[i] <= r_count[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Registered broadcast, grant id and round-robin pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cdb      <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else if (squash) begin
      r_cdb.valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (w_found) begin
      r_cdb      <= w_cdb_next;
      r_grant_id <= w_winner;
      r_rr_ptr   <= w_rr_next;
    end else begin
      r_cdb.valid <= 1'b0;
    end
  end

  assign bus.req_ready       = w_ready;
  assign bus.cdb_packet      = r_cdb;
  assign bus.grant_id        = r_grant_id;
  assign bus.wb_regfile_en   = r_cdb.valid && (r_cdb.dest_reg_idx != ZERO_REG);
  assign bus.wb_regfile_idx  = r_cdb.dest_reg_idx;
  assign bus.wb_regfile_data = r_cdb.Value;
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) and architectural writeback port among several execution units. Each unit hands completed `EX_PACKET`s to a small per-requester FIFO. A round-robin arbiter picks one head entry per cycle and converts it into a registered `CDB_PACKET` plus register-file write signals. The block sits between the functional units' output registers and the ROB/RS/regfile consumers, and it replaces the single-source writeback stage.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesting units (ALU0, ALU1, MULT, LSQ). Legal values are 2 to 8.
- `DEPTH`, 2: entries per requester FIFO. Legal values are 2 or 4.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low (asserts at 0 without waiting for a clock edge; deassertion is synchronous to `clock` at the source).
- `squash`  in  1  synchronous flush for branch mispredict.
- `req_valid`  in  `NUM_REQ`  requester i presents a packet.
- `req_packet`  in  `NUM_REQ` x `EX_PACKET`  completed instruction per requester.
- `req_ready`  out  `NUM_REQ`  FIFO i can accept this cycle.
- `cdb_packet`  out  `CDB_PACKET`  registered broadcast; `cdb_packet.valid` qualifies it.
- `wb_regfile_en`  out  1  architectural write enable.
- `wb_regfile_idx`  out  5  write index.
- `wb_regfile_data`  out  `XLEN`  write data.
- `grant_id`  out  `$clog2(NUM_REQ)`  index of the requester driving the current `cdb_packet`.

## Operation

- **FIFO per requester.** Each FIFO is a circular buffer with a head pointer, a tail pointer and a count of width `$clog2(DEPTH)+1`. Pointers wrap modulo `DEPTH`.
- **Ready.** `req_ready[i] = (count_i != DEPTH) && reset`. Ready is computed from registered count only, so it is not raised by a same-cycle dequeue and there is no bypass. Ready is 0 while `reset` is asserted.
- **Enqueue.** A push happens when `req_valid[i] && req_ready[i]`. `req_valid` while not ready is ignored; the requester must hold its packet.
- **Arbitration.** Search starts at `rr_ptr` and the first FIFO with `count != 0` wins. Only one pop is made per cycle.
- **Pointer update.** After a pop, `rr_ptr <= (winner + 1) mod NUM_REQ`. If nothing is popped, `rr_ptr` holds.
- **Push and pop in the same cycle on one FIFO.** Count is unchanged and both pointers advance.
- **Packet conversion** (registered, applied to the winning head entry):
  - inst, PC, NPC, dest_reg_idx, halt, illegal, Tag and alu_result are copied.
  - `take_branch = take_branch && valid`.
  - `Value = take_branch ? NPC : alu_result`.
  - `done = 0`.
  - `valid = 1`.
- **No winner.** `cdb_packet.valid <= 0` and the other fields hold.
- **Regfile outputs.** These are combinational from the registered CDB:
  - `wb_regfile_en = cdb_packet.valid && dest_reg_idx != ZERO_REG`.
  - `wb_regfile_idx = cdb_packet.dest_reg_idx`.
  - `wb_regfile_data = cdb_packet.Value`.
- **Squash.** On the next edge all counts and pointers clear, `rr_ptr <= 0` and `cdb_packet.valid <= 0`. Pushes and pops in the squash cycle are discarded. `squash` overrides all other activity.
- **Reset values.** All FIFO counts and pointers are 0 and `rr_ptr` is 0. `cdb_packet` is all-zero, so valid is 0. `grant_id`, `wb_regfile_en`, `wb_regfile_idx` and `wb_regfile_data` are 0 and `req_ready` is all-0. Assertion mid-transfer drops every buffered packet immediately.

## Timing

- Minimum latency from accepted push to `cdb_packet.valid` is 2 cycles. The packet is written into the FIFO at edge N, wins arbitration in cycle N, and appears on the CDB after edge N+1.
- Throughput is 1 CDB packet per cycle total.
- With `k` FIFOs continuously non-empty, each is served at least once every `k` cycles, so there is no starvation.
- A full FIFO (`count == DEPTH`) deasserts ready for the entire cycle, even if it pops in that same cycle. Ready reasserts the cycle after the pop.
- The first `req_ready` high is seen one cycle after `reset` deasserts.

## Test plan

- **Reset:** hold `reset=0` and push on all ports → `req_ready=0000`, `cdb_packet.valid=0`, `wb_regfile_en=0`. Release reset → ready is `1111` on the next cycle.
- **Single push:** `req_valid[2]=1`, dest=5, alu_result=`0x1234`, take_branch=0 → 2 cycles later `cdb_packet.valid=1`, `Value=0x1234`, `grant_id=2`, `wb_regfile_en=1`, idx=5. With dest=0 → `wb_regfile_en=0` but the CDB is still valid.
- **Taken branch:** take_branch=1, NPC=`0x108`, alu_result=`0x200` → `Value=0x108`, `wb_regfile_data=0x108`, `cdb_packet.take_branch=1`.
- **Round-robin fairness:** all 4 FIFOs loaded with 2 entries each in the same cycle → grants are 0,1,2,3,0,1,2,3 over 8 consecutive cycles, then the CDB goes idle.
- **Backpressure and FIFO wrap:** requester 1 pushes every cycle while requester 0 is also busy → `req_ready[1]` drops to 0 after 2 accepted pushes. The 5 accepted packets emerge in order with no loss or duplication.
- **Squash mid-flight:** 3 packets buffered, assert `squash` for 1 cycle → next cycle all counts are 0 and `cdb_packet.valid=0`. A packet pushed in the squash cycle never appears on the CDB.
